// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Desc     : Shared types and constants for the mem_arbiter slice.
// Revision : 1.0
// ============================================================================
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // Fill pattern returned on a timed-out read; sliced to DATA_W by users.
    localparam logic [MAX_DATA_W-1:0] ARB_ERR_DATA = '1;

    function automatic logic grant_is_m1(input logic [1:0] g);
        return g == GRANT_M1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Desc     : Requester (m0/m1) and memory-side bus bundle of the arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              m0_valid;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ready;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_valid;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ready;
    logic [DATA_W-1:0] m1_rdata;

    logic              m_err;
    logic [1:0]        grant;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  m0_valid, m0_we, m0_addr, m0_wdata,
        output m0_ready, m0_rdata,
        input  m1_valid, m1_we, m1_addr, m1_wdata,
        output m1_ready, m1_rdata,
        output m_err, grant,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output m0_valid, m0_we, m0_addr, m0_wdata,
        input  m0_ready, m0_rdata,
        output m1_valid, m1_we, m1_addr, m1_wdata,
        input  m1_ready, m1_rdata,
        input  m_err, grant,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Desc     : Combinational winner select; MEM_ARB_RR_EN enables round-robin,
//            otherwise m0 has fixed priority.
// Revision : 1.0
// ============================================================================
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       m0_valid_i,
    input  logic       m1_valid_i,
`ifdef MEM_ARB_RR_EN
    input  logic       prio_m1_i,
`endif
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = GRANT_NONE;
        case ({m1_valid_i, m0_valid_i})
            2'b01:   grant_o = GRANT_M0;
            2'b10:   grant_o = GRANT_M1;
`ifdef MEM_ARB_RR_EN
            2'b11:   grant_o = prio_m1_i ? GRANT_M1 : GRANT_M0;
`else
            2'b11:   grant_o = GRANT_M0;
`endif
            default: grant_o = GRANT_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Desc     : Serialises m0 (CPU) and m1 (loader) onto one memory port with an
//            ack timeout. Define MEM_ARB_RR_EN for round-robin arbitration.
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam bit              TO_EN    = (TIMEOUT > 0);
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_t        state_q;
    logic [1:0]        grant_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              m0_ready_q;
    logic              m1_ready_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0]        w_pick;
    logic              w_timeout;
    logic              w_done;
    logic [DATA_W-1:0] w_rsp_data;

`ifdef MEM_ARB_RR_EN
    // Names the requester favoured on a tie: the one not served last.
    logic              prio_q;
`endif

    mem_arb_pick u_pick (
        .m0_valid_i (bus.m0_valid),
        .m1_valid_i (bus.m1_valid),
`ifdef MEM_ARB_RR_EN
        .prio_m1_i  (prio_q),
`endif
        .grant_o    (w_pick)
    );

    // An ack in the final allowed cycle beats the timeout.
    assign w_timeout  = TO_EN && (cnt_q == CNT_LAST) && !bus.mem_ack;
    assign w_done     = bus.mem_ack || w_timeout;
    assign w_rsp_data = bus.mem_ack ? bus.mem_rdata : ARB_ERR_DATA[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= GRANT_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m0_ready_q  <= 1'b0;
            m1_ready_q  <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
`ifdef MEM_ARB_RR_EN
            prio_q      <= 1'b0;
`endif
        end else begin
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (w_pick != GRANT_NONE) begin
                        grant_q   <= w_pick;
                        mem_req_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ARB_BUSY;
                        if (w_pick == GRANT_M1) begin
                            mem_we_q    <= bus.m1_we;
                            mem_addr_q  <= bus.m1_addr;
                            mem_wdata_q <= bus.m1_wdata;
                        end else begin
                            mem_we_q    <= bus.m0_we;
                            mem_addr_q  <= bus.m0_addr;
                            mem_wdata_q <= bus.m0_wdata;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (w_done) begin
                        mem_req_q  <= 1'b0;
                        state_q    <= ARB_RESP;
                        m0_ready_q <= (grant_q == GRANT_M0);
                        m1_ready_q <= (grant_q == GRANT_M1);
                        err_q      <= w_timeout;
                        if (!mem_we_q) begin
                            if (grant_q == GRANT_M1) begin
                                m1_rdata_q <= w_rsp_data;
                            end else begin
                                m0_rdata_q <= w_rsp_data;
                            end
                        end
`ifdef MEM_ARB_RR_EN
                        prio_q <= !grant_is_m1(grant_q);
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ARB_RESP: begin
                    grant_q <= GRANT_NONE;
                    state_q <= ARB_IDLE;
                end
                default: begin
                    grant_q   <= GRANT_NONE;
                    mem_req_q <= 1'b0;
                    state_q   <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.m0_ready  = m0_ready_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_ready  = m1_ready_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.m_err     = err_q;
    assign bus.grant     = grant_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Desc     : Randomised scoreboard bench for mem_arbiter (either policy).
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int N_TXN   = 40;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        longint      cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_fail = 0;
    longint      cyc = 0;
    logic        tx_we[2];
    logic [31:0] tx_addr[2];
    logic [31:0] tx_wdata[2];
    logic [1:0]  v_snap = 2'b00;
    logic [31:0] mem_model[logic [31:0]];
    logic [31:0] last_rd[2];
    int          last_srv = 1;
    logic [1:0]  grant_prev = 2'b00;
    int          force_lat = -1;
    int          lat_d = 0;
    int          busy_n = 0;
    int          w_id;
    int          n_cyc;
    logic        e_err;
    logic [31:0] rsp_data = '0;
    logic [31:0] exp_addr = '0;
    exp_t        pe;
    exp_t        me;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h8C01_0004;
    endfunction

    task automatic set_req(input int id, input logic v);
        if (id == 0) begin
            bus.m0_valid = v;
            bus.m0_we    = tx_we[0];
            bus.m0_addr  = tx_addr[0];
            bus.m0_wdata = tx_wdata[0];
        end else begin
            bus.m1_valid = v;
            bus.m1_we    = tx_we[1];
            bus.m1_addr  = tx_addr[1];
            bus.m1_wdata = tx_wdata[1];
        end
    endtask

    function automatic logic ready_of(input int id);
        return (id == 0) ? bus.m0_ready : bus.m1_ready;
    endfunction

    task automatic drive(input int id, input int n);
        int gap;
        int waited;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            tx_we[id]    = ($urandom_range(0, 1) == 1);
            tx_addr[id]  = 32'h100 + (32'($urandom_range(0, 7)) << 2);
            tx_wdata[id] = $urandom;
            set_req(id, 1'b1);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!ready_of(id) && waited < 3000);
            if (!ready_of(id)) chk("ready_wait", ready_of(id), 1'b1);
            set_req(id, 1'b0);
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        v_snap <= {bus.m1_valid, bus.m0_valid};
    end

    // Arbitration model, expectation push and memory responder.
    always @(negedge clk) begin
        if (!rst) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            sb.delete();
            last_rd[0] = '0;
            last_rd[1] = '0;
            last_srv   = 1;
            grant_prev = 2'b00;
            busy_n     = 0;
        end else begin
            if (grant_prev == 2'b00 && bus.grant != 2'b00) begin
                if (v_snap == 2'b00) chk("grant_without_valid", bus.grant, 2'b00);
                if (v_snap == 2'b11) begin
`ifdef MEM_ARB_RR_EN
                    w_id = 1 - last_srv;
`else
                    w_id = 0;
`endif
                end else begin
                    w_id = v_snap[1] ? 1 : 0;
                end
                chk("grant_winner", bus.grant, (w_id == 1) ? 2'b10 : 2'b01);
                chk("mem_req_up", bus.mem_req, 1'b1);
                chk("mem_we", bus.mem_we, tx_we[w_id]);
                chk("mem_addr", bus.mem_addr, tx_addr[w_id]);
                chk("mem_wdata", bus.mem_wdata, tx_wdata[w_id]);
                if (force_lat >= 0) begin
                    lat_d = force_lat;
                end else begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4, 5: lat_d = $urandom_range(0, 3);
                        6, 7:             lat_d = $urandom_range(4, TIMEOUT - 2);
                        default:          lat_d = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
                    endcase
                end
                e_err = (lat_d + 1 > TIMEOUT);
                n_cyc = e_err ? TIMEOUT : lat_d + 1;
                pe.id  = w_id;
                pe.err = e_err;
                pe.cyc = cyc + n_cyc;
                if (tx_we[w_id]) begin
                    pe.rdata = last_rd[w_id];
                    rsp_data = $urandom;
                    if (!e_err) mem_model[tx_addr[w_id]] = tx_wdata[w_id];
                end else begin
                    rsp_data = mem_rd(tx_addr[w_id]);
                    pe.rdata = e_err ? 32'hFFFF_FFFF : rsp_data;
                    last_rd[w_id] = pe.rdata;
                end
                sb.push_back(pe);
                last_srv = w_id;
                exp_addr = tx_addr[w_id];
                busy_n   = 0;
            end
            grant_prev = bus.grant;

            if (bus.mem_req) begin
                busy_n++;
                if (busy_n == lat_d + 1) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rsp_data;
                    chk("mem_addr_stable", bus.mem_addr, exp_addr);
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end else begin
                busy_n        = 0;
                bus.mem_ack   = ($urandom_range(0, 3) == 0);
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Monitor: every ready/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && (bus.m0_ready || bus.m1_ready || bus.m_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", {bus.m_err, bus.m1_ready, bus.m0_ready}, 3'b000);
            end else begin
                me = sb.pop_front();
                chk("ready_onehot", {bus.m1_ready, bus.m0_ready}, (me.id == 1) ? 2'b10 : 2'b01);
                chk("rdata", (me.id == 1) ? bus.m1_rdata : bus.m0_rdata, me.rdata);
                chk("m_err", bus.m_err, me.err);
                chk("ready_cycle", cyc, me.cyc);
                chk("grant_in_resp", bus.grant, (me.id == 1) ? 2'b10 : 2'b01);
            end
        end
    end

    initial begin
        int waited;
        tx_we[0] = 1'b0; tx_addr[0] = '0; tx_wdata[0] = '0;
        tx_we[1] = 1'b0; tx_addr[1] = '0; tx_wdata[1] = '0;
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 2'b00);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_ready", {bus.m1_ready, bus.m0_ready}, 2'b00);
        chk("rst_m_err", bus.m_err, 1'b0);
        chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
        chk("rst_m1_rdata", bus.m1_rdata, 32'h0);
        rst = 1'b1;

        fork
            drive(0, N_TXN);
            drive(1, N_TXN);
        join
        repeat (4) @(negedge clk);
        chk("sb_drained_random", sb.size(), 0);

        // Reset while a read is hanging in the busy state.
        force_lat = 1000;
        tx_we[0] = 1'b0; tx_addr[0] = 32'h40; tx_wdata[0] = 32'h0;
        set_req(0, 1'b1);
        waited = 0;
        while (!bus.mem_req && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("midop_mem_req_up", bus.mem_req, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midop_rst_mem_req", bus.mem_req, 1'b0);
        chk("midop_rst_grant", bus.grant, 2'b00);
        chk("midop_rst_ready", bus.m0_ready, 1'b0);
        @(negedge clk);
        force_lat = 0;
        rst = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.m0_ready && waited < 40);
        chk("post_rst_read_done", bus.m0_ready, 1'b1);
        set_req(0, 1'b0);
        repeat (4) @(negedge clk);
        chk("sb_drained_final", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: run did not complete, got timeout, expected summary");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
